icache: RTL
===========

Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the datapath fetch stage and the memory controller's instruction port.
- Serves fetch hits combinationally.
- On a miss, runs a two-word block fill over the controller's iREN/iaddr/iwait/iload handshake.
- The controller may stall a fill indefinitely, for example while it gives data traffic priority.

Parameters:
- SETS, 8, number of frames (power of 2, ≥2); IDX_W = $clog2(SETS).
- Block size is fixed at 2 words. Byte offset is 2 bits, block offset is 1 bit, TAG_W = 29 - IDX_W.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  fetch byte address (word-aligned).
- ihit  output  1  fetch data valid this cycle.
- imemload  output  32  fetched instruction.
- iflush  input  1  invalidate all frames.
- iREN  output  1  read request to memory controller.
- iaddr  output  32  read address to memory controller.
- iwait  input  1  controller stall; 0 means iload is valid this cycle.
- iload  input  32  read data from controller.

Behaviour:
- Address split: tag = [31:IDX_W+3], idx = [IDX_W+2:3], blkoff = [2], bytoff = [1:0] (ignored).
- Storage per frame: valid, tag, and two data words.
- Reset (RST high at an edge):
  - all valid bits cleared, state = IDLE, pending-discard flag cleared.
  - outputs during and after reset: ihit=0, iREN=0, iaddr=0, imemload=0.
- State IDLE:
  - hit = imemREN & valid[idx] & tag match. ihit=hit and imemload = data[idx][blkoff], same cycle (0 latency).
  - On a miss with imemREN=1: latch {tag, idx} into the miss register and go to FILL0 at the next edge.
  - When imemREN=0: ihit=0, no state change.
- State FILL0:
  - iREN=1, iaddr={miss_tag, miss_idx, 1'b0, 2'b00}.
  - On an edge with iwait=0: write iload into data[miss_idx][0], go to FILL1.
- State FILL1:
  - iREN=1, iaddr={miss_tag, miss_idx, 1'b1, 2'b00}.
  - On an edge with iwait=0: write word 1 and the tag. Set valid unless the discard flag is set, clear the flag, go to IDLE.
- In all non-IDLE states: ihit=0 and imemload=0.
- iREN and iaddr are stable while iwait=1, for any number of cycles.
- A fill always completes once started, even if imemREN drops or imemaddr changes. The next lookup uses the then-current imemaddr.
- Fill latency: 2 accepted words plus 1 cycle back in IDLE; hit asserts in the first IDLE cycle after FILL1.
- iflush in IDLE: all valid bits cleared at the edge. ihit is still evaluated on the pre-flush state that cycle.
- iflush in FILL0/FILL1: clears all valid bits and sets the discard flag, so the in-flight line is not marked valid.
- Simultaneous RST and iflush: RST dominates.
- Eviction: a miss overwrites the frame with no writeback (read-only cache).
- RST mid-fill: abandon the fill and go to IDLE; iREN=0 from the cycle after the edge. The partially written frame stays invalid.
- iwait=0 while iREN=0 is ignored.

Decomposition:
- cpu_types_pkg gains:
  - icachef_t packed struct {tag, idx, blkoff, bytoff}
  - icache_state_t enum {IDLE, FILL0, FILL1}
  - ICACHE_SETS constant
- One sub-module, icache_frame_array: valid/tag/data storage. It provides a combinational read port plus a word-write port with tag/valid-set enables and an invalidate-all.
- The FSM and miss register stay in icache.

Test Plan (SETS=8):
- Cold miss, then hits:
  - Stimulus: after reset, imemREN=1, imemaddr=0x00000044. Controller holds iwait=1 for 2 cycles, then returns iload=0xAAAA0001 for 0x40 and 0xAAAA0002 for 0x44.
  - Required: ihit=0 and iREN=1 with iaddr=0x40, then 0x44. The next cycle gives ihit=1, imemload=0xAAAA0002. Address 0x40 then hits with 0xAAAA0001 and no iREN.
- Conflict eviction:
  - Stimulus: after the first scenario, fetch 0x00000080 (same idx 0, new tag).
  - Required: fill from 0x80/0x84. A later fetch of 0x40 misses again with iREN=1.
- Long stall:
  - Stimulus: hold iwait=1 for 20 cycles in FILL0.
  - Required: iREN=1 and iaddr constant all 20 cycles; ihit=0.
- Flush:
  - In IDLE, pulse iflush. Required: a previously hitting 0x40 misses next cycle.
  - Pulse iflush in FILL1. Required: the fill completes, and a fetch of the same address misses again.
- Reset mid-fill:
  - Stimulus: RST high during FILL0.
  - Required: iREN=0, ihit=0 the next cycle; a fetch of the line misses.
- No request:
  - Stimulus: imemREN=0 with valid lines present.
  - Required: ihit=0, iREN=0, imemload=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types used by the instruction cache.
//   icachef_t      - fetch address split {tag, idx, blkoff, bytoff}
//   icache_state_t - fill sequencer states
//   ICACHE_SETS    - default number of direct-mapped frames
package cpu_types_pkg;

    localparam int ICACHE_SETS  = 8;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 29 - ICACHE_IDX_W;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic                    blkoff;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL0 = 2'd1,
        FILL1 = 2'd2
    } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// icache_frame_array: valid/tag/data storage for a direct-mapped,
// two-word-block instruction cache.
//   i_clk, i_rst            - clock, synchronous active-high reset
//   i_ridx                  - combinational read index
//   o_valid/o_tag/o_word0/1 - contents of frame i_ridx
//   i_we, i_widx, i_wword,
//   i_wdata                 - write one data word of frame i_widx
//   i_tag_we, i_tag         - write the tag of frame i_widx
//   i_valid_set             - mark frame i_widx valid
//   i_inv_all               - clear every valid bit (beats i_valid_set)
module icache_frame_array #(
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 29 - IDX_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_ridx,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag,
    output logic [31:0]      o_word0,
    output logic [31:0]      o_word1,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic             i_wword,
    input  logic [31:0]      i_wdata,
    input  logic             i_tag_we,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_valid_set,
    input  logic             i_inv_all
);

    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag   [SETS];
    logic [31:0]      r_word0 [SETS];
    logic [31:0]      r_word1 [SETS];

    // Valid bits: cleared by reset or invalidate-all, set at fill completion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (i_inv_all) begin
            r_valid <= '0;
        end else if (i_valid_set) begin
            r_valid[i_widx] <= 1'b1;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Tag and data payload; contents are meaningless while the valid bit is low.
    always_ff @(posedge i_clk) begin
        if (i_tag_we) begin
            r_tag[i_widx] <= i_tag;
        end
        if (i_we) begin
            if (i_wword) begin
                r_word1[i_widx] <= i_wdata;
            end else begin
                r_word0[i_widx] <= i_wdata;
            end
        end
    end

    assign o_valid = r_valid[i_ridx];
    assign o_tag   = r_tag[i_ridx];
    assign o_word0 = r_word0[i_ridx];
    assign o_word1 = r_word1[i_ridx];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache, 2-word blocks.
//   CLK, RST            - clock, synchronous active-high reset
//   imemREN, imemaddr   - fetch request / byte address from the datapath
//   ihit, imemload      - same-cycle hit and instruction (0 when no hit)
//   iflush              - invalidate all frames
//   iREN, iaddr         - block-fill read request to the memory controller
//   iwait, iload        - controller stall (0 = iload valid) and read data
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iflush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 29 - IDX_W;

    icache_state_t    r_state;
    logic [TAG_W-1:0] r_miss_tag;
    logic [IDX_W-1:0] r_miss_idx;
    logic             r_discard;

    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_idx;
    logic             w_blkoff;
    logic             w_unused_bytoff;
    logic             w_rd_valid;
    logic [TAG_W-1:0] w_rd_tag;
    logic [31:0]      w_rd_word0;
    logic [31:0]      w_rd_word1;
    logic             w_idle;
    logic             w_fill1;
    logic             w_lookup_hit;
    logic             w_hit;
    logic             w_accept;
    logic             w_complete;

    assign w_tag           = imemaddr[31:IDX_W+3];
    assign w_idx           = imemaddr[IDX_W+2:3];
    assign w_blkoff        = imemaddr[2];
    assign w_unused_bytoff = &{1'b0, imemaddr[1:0]};

    assign w_idle       = (r_state == IDLE);
    assign w_fill1      = (r_state == FILL1);
    assign w_lookup_hit = imemREN & w_rd_valid & (w_rd_tag == w_tag);
    // Reset forces every output low even while the state register still shows a fill.
    assign w_hit        = ~RST & w_idle & w_lookup_hit;
    assign w_accept     = ~RST & ~w_idle & ~iwait;
    assign w_complete   = w_accept & w_fill1;

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_frames (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_ridx      (w_idx),
        .o_valid     (w_rd_valid),
        .o_tag       (w_rd_tag),
        .o_word0     (w_rd_word0),
        .o_word1     (w_rd_word1),
        .i_we        (w_accept),
        .i_widx      (r_miss_idx),
        .i_wword     (w_fill1),
        .i_wdata     (iload),
        .i_tag_we    (w_complete),
        .i_tag       (r_miss_tag),
        // A flush landing on the completing edge must also keep the line invalid.
        .i_valid_set (w_complete & ~r_discard & ~iflush),
        .i_inv_all   (iflush)
    );

    assign ihit     = w_hit;
    assign imemload = w_hit ? (w_blkoff ? w_rd_word1 : w_rd_word0) : 32'd0;
    assign iREN     = ~RST & ~w_idle;
    assign iaddr    = iREN ? {r_miss_tag, r_miss_idx, w_fill1, 2'b00} : 32'd0;

    // Fill sequencer: miss capture, two-word fill, flush-during-fill discard flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_miss_tag <= '0;
            r_miss_idx <= '0;
            r_discard  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (imemREN && !w_lookup_hit) begin
                        r_miss_tag <= w_tag;
                        r_miss_idx <= w_idx;
                        r_state    <= FILL0;
                    end
                end
                FILL0: begin
                    if (iflush) begin
                        r_discard <= 1'b1;
                    end
                    if (!iwait) begin
                        r_state <= FILL1;
                    end
                end
                FILL1: begin
                    if (!iwait) begin
                        r_discard <= 1'b0;
                        r_state   <= IDLE;
                    end else if (iflush) begin
                        r_discard <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
